// File: rtl/ahb_reg_slave_if.sv
// AHB-lite bus bundle between a master and the register slave.
//   master modport: drives hsel/haddr/htrans/hwrite/hwdata, sees hrdata/hresp/hready
//   slave modport : the reverse
interface ahb_reg_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic [1:0]  hresp;
  logic        hready;

  modport master (
    output hsel, haddr, htrans, hwrite, hwdata,
    input  hrdata, hresp, hready
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hwdata,
    output hrdata, hresp, hready
  );
endinterface

// File: rtl/ahb_reg_slave.sv
// AHB-lite slave exposing NUM_WORDS 32-bit registers at BASE_ADDR.
// Every OKAY data phase is stretched by WAIT_STATES wait cycles; misaligned or
// out-of-window addresses get the two-cycle ERROR response and touch nothing.
//   hclk   : clock, all state on its rising edge
//   hreset : synchronous active-high reset (clears FSM and all registers)
//   bus    : ahb_reg_slave_if.slave (hsel/haddr/htrans/hwrite/hwdata in,
//            hrdata/hresp/hready out)
module ahb_reg_slave #(
  parameter int unsigned NUM_WORDS   = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic           hclk,
  input  logic           hreset,
  ahb_reg_slave_if.slave bus
);

  localparam int unsigned IdxW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [31:0] NumBytes = 32'(NUM_WORDS * 4);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StLast,
    StErr1,
    StErr2
  } state_t;

  state_t          state_q;
  logic [2:0]      wait_cnt_q;
  logic [IdxW-1:0] idx_q;
  logic            write_q;
  logic [31:0]     regs_q [NUM_WORDS];

  // Address decode for the address phase currently on the bus
  logic [31:0]     offset;
  logic            dec_err;
  logic [IdxW-1:0] dec_idx;
  logic            hready;
  logic            accept;
  state_t          launch_state;
  logic [2:0]      launch_cnt;

  // NONSEQ vs SEQ makes no difference to a single-register slave
  logic unused_htrans0;
  assign unused_htrans0 = bus.htrans[0];

  always_comb begin
    offset  = bus.haddr - BASE_ADDR;
    dec_err = (bus.haddr[1:0] != 2'b00) || (bus.haddr < BASE_ADDR) || (offset >= NumBytes);
    dec_idx = offset[IdxW+1:2];
  end

  // hready is a pure decode of the state so the master sees it straight off a flop
  always_comb begin
    hready     = !(state_q inside {StWait, StErr1});
    bus.hready = hready;
    bus.hresp  = (state_q inside {StErr1, StErr2}) ? 2'b01 : 2'b00;
    bus.hrdata = (state_q == StLast && !write_q) ? regs_q[idx_q] : 32'h0;
  end

  assign accept = bus.hsel && bus.htrans[1] && hready && !hreset;

  // Where a freshly accepted transfer starts its data phase
  always_comb begin
    if (dec_err) begin
      launch_state = StErr1;
      launch_cnt   = '0;
    end else if (WAIT_STATES > 0) begin
      launch_state = StWait;
      launch_cnt   = 3'(WAIT_STATES - 1);
    end else begin
      launch_state = StLast;
      launch_cnt   = '0;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else begin
      // Write data is only valid in the final OKAY data-phase cycle
      if (state_q == StLast && write_q) begin
        regs_q[idx_q] <= bus.hwdata;
      end

      if (accept) begin
        idx_q      <= dec_idx;
        write_q    <= bus.hwrite;
        state_q    <= launch_state;
        wait_cnt_q <= launch_cnt;
      end else begin
        case (state_q)
          StWait: begin
            if (wait_cnt_q == 3'd0) begin
              state_q <= StLast;
            end else begin
              wait_cnt_q <= wait_cnt_q - 3'd1;
            end
          end
          StErr1:  state_q <= StErr2;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Directed bench for ahb_reg_slave. Three instances share one stimulus bus:
// u_dut0 WAIT_STATES=1, u_dut1 WAIT_STATES=0, u_dut2 WAIT_STATES=3.
module tb_ahb_reg_slave;

  localparam logic [1:0] TrIdle   = 2'b00;
  localparam logic [1:0] TrBusy   = 2'b01;
  localparam logic [1:0] TrNonseq = 2'b10;
  localparam logic [1:0] TrSeq    = 2'b11;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;

  logic [2:0]       rdy;
  logic [2:0][1:0]  rsp;
  logic [2:0][31:0] rdat;

  int checks   = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  ahb_reg_slave_if u_if0 ();
  ahb_reg_slave_if u_if1 ();
  ahb_reg_slave_if u_if2 ();

  assign u_if0.hsel = hsel;  assign u_if0.haddr = haddr;  assign u_if0.htrans = htrans;
  assign u_if0.hwrite = hwrite;  assign u_if0.hwdata = hwdata;
  assign u_if1.hsel = hsel;  assign u_if1.haddr = haddr;  assign u_if1.htrans = htrans;
  assign u_if1.hwrite = hwrite;  assign u_if1.hwdata = hwdata;
  assign u_if2.hsel = hsel;  assign u_if2.haddr = haddr;  assign u_if2.htrans = htrans;
  assign u_if2.hwrite = hwrite;  assign u_if2.hwdata = hwdata;

  assign rdy[0] = u_if0.hready;  assign rsp[0] = u_if0.hresp;  assign rdat[0] = u_if0.hrdata;
  assign rdy[1] = u_if1.hready;  assign rsp[1] = u_if1.hresp;  assign rdat[1] = u_if1.hrdata;
  assign rdy[2] = u_if2.hready;  assign rsp[2] = u_if2.hresp;  assign rdat[2] = u_if2.hrdata;

  ahb_reg_slave #(.NUM_WORDS(16), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_dut0 (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (u_if0)
  );
  ahb_reg_slave #(.NUM_WORDS(16), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut1 (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (u_if1)
  );
  ahb_reg_slave #(.NUM_WORDS(16), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_dut2 (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (u_if2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read at the same point
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = TrIdle;
    hwrite = 1'b0;
    haddr  = 32'h0;
  endtask

  task automatic do_reset();
    idle_bus();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
  endtask

  // One NONSEQ transfer watched on instance d; returns in its final data-phase cycle
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, output logic [31:0] rd,
                      output int waits, output logic [1:0] resp);
    hsel   = 1'b1;
    htrans = TrNonseq;
    hwrite = wr;
    haddr  = addr;
    tick();
    idle_bus();
    hwdata = data;
    waits  = 0;
    while (!rdy[d] && waits < 16) begin
      waits++;
      tick();
    end
    check_eq("xfer_done", 32'(rdy[d]), 32'd1);
    rd   = rdat[d];
    resp = rsp[d];
  endtask

  logic [31:0] rd;
  logic [1:0]  resp;
  int          waits;
  logic [31:0] exp_mem [16];

  initial begin
    hwdata = 32'h0;
    idle_bus();
    hreset = 1'b1;
    tick();
    do_reset();

    // Reset state on all three instances
    for (int d = 0; d < 3; d++) begin
      check_eq("rst_hready", 32'(rdy[d]), 32'd1);
      check_eq("rst_hresp", 32'(rsp[d]), 32'd0);
      check_eq("rst_hrdata", rdat[d], 32'h0);
    end

    // WAIT_STATES=1: read index 3 after reset
    xfer(0, 1'b0, 32'h0000_000C, 32'h0, rd, waits, resp);
    check_eq("ws1_read_waits", 32'(waits), 32'd1);
    check_eq("ws1_read_data", rd, 32'h0);
    check_eq("ws1_read_resp", 32'(resp), 32'd0);
    tick();

    // WAIT_STATES=0: write then read back at full rate
    do_reset();
    hsel = 1'b1;  htrans = TrNonseq;  hwrite = 1'b1;  haddr = 32'h8;
    tick();
    check_eq("b2b_wr_ready", 32'(rdy[1]), 32'd1);
    hwdata = 32'hDEAD_BEEF;  htrans = TrSeq;  hwrite = 1'b0;  haddr = 32'h8;
    tick();
    check_eq("raw_ready", 32'(rdy[1]), 32'd1);
    check_eq("raw_data", rdat[1], 32'hDEAD_BEEF);
    hwrite = 1'b1;  htrans = TrNonseq;  haddr = 32'h0;
    tick();
    hwdata = 32'h0123_4567;  htrans = TrSeq;  haddr = 32'h4;
    tick();
    check_eq("burst_wr_hrdata", rdat[1], 32'h0);
    check_eq("burst_wr_ready", 32'(rdy[1]), 32'd1);
    hwdata = 32'h89AB_CDEF;  hwrite = 1'b0;  haddr = 32'h0;
    tick();
    check_eq("burst_rd0", rdat[1], 32'h0123_4567);
    haddr = 32'h4;
    tick();
    check_eq("burst_rd1", rdat[1], 32'h89AB_CDEF);
    idle_bus();
    tick();
    check_eq("idle_hrdata", rdat[1], 32'h0);

    // Out-of-range then unaligned write, back to back through ERR2
    hsel = 1'b1;  htrans = TrNonseq;  hwrite = 1'b1;  haddr = 32'h40;
    tick();
    check_eq("oor_err1_ready", 32'(rdy[1]), 32'd0);
    check_eq("oor_err1_resp", 32'(rsp[1]), 32'd1);
    hwdata = 32'hBAD0_BAD0;
    idle_bus();
    tick();
    check_eq("oor_err2_ready", 32'(rdy[1]), 32'd1);
    check_eq("oor_err2_resp", 32'(rsp[1]), 32'd1);
    hsel = 1'b1;  htrans = TrNonseq;  hwrite = 1'b1;  haddr = 32'h2;
    tick();
    check_eq("unal_err1_ready", 32'(rdy[1]), 32'd0);
    check_eq("unal_err1_resp", 32'(rsp[1]), 32'd1);
    idle_bus();
    tick();
    check_eq("unal_err2_resp", 32'(rsp[1]), 32'd1);
    tick();
    check_eq("err_idle_resp", 32'(rsp[1]), 32'd0);

    for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
    exp_mem[0] = 32'h0123_4567;
    exp_mem[1] = 32'h89AB_CDEF;
    exp_mem[2] = 32'hDEAD_BEEF;
    for (int i = 0; i < 16; i++) begin
      hsel = 1'b1;  htrans = (i == 0) ? TrNonseq : TrSeq;  hwrite = 1'b0;  haddr = 32'(i * 4);
      tick();
      check_eq("readback", rdat[1], exp_mem[i]);
    end
    idle_bus();
    tick();

    // WAIT_STATES=3: exactly three wait cycles; bus activity during them is ignored
    do_reset();
    hsel = 1'b1;  htrans = TrNonseq;  hwrite = 1'b1;  haddr = 32'h10;
    tick();
    hwdata = 32'h0000_1234;
    for (int w = 0; w < 3; w++) begin
      check_eq("ws3_wait", 32'(rdy[2]), 32'd0);
      hsel = 1'b1;  htrans = (w == 1) ? TrSeq : TrNonseq;  hwrite = 1'b1;  haddr = 32'h14;
      tick();
    end
    check_eq("ws3_last_ready", 32'(rdy[2]), 32'd1);
    idle_bus();
    tick();
    check_eq("ws3_idle_ready", 32'(rdy[2]), 32'd1);
    xfer(2, 1'b0, 32'h10, 32'h0, rd, waits, resp);
    check_eq("ws3_rd_waits", 32'(waits), 32'd3);
    check_eq("ws3_rd_data", rd, 32'h0000_1234);
    xfer(2, 1'b0, 32'h14, 32'h0, rd, waits, resp);
    check_eq("ws3_ignored_wr", rd, 32'h0);
    tick();

    // Reset during the second wait cycle of a write to index 5
    hsel = 1'b1;  htrans = TrNonseq;  hwrite = 1'b1;  haddr = 32'h14;
    tick();
    hwdata = 32'h0000_FFFF;
    idle_bus();
    tick();
    check_eq("abort_in_wait", 32'(rdy[2]), 32'd0);
    hreset = 1'b1;
    hsel = 1'b1;  htrans = TrNonseq;  hwrite = 1'b0;  haddr = 32'h14;
    tick();
    hreset = 1'b0;
    idle_bus();
    check_eq("abort_ready", 32'(rdy[2]), 32'd1);
    check_eq("abort_resp", 32'(rsp[2]), 32'd0);
    tick();
    check_eq("no_accept_in_rst", 32'(rdy[2]), 32'd1);
    xfer(2, 1'b0, 32'h14, 32'h0, rd, waits, resp);
    check_eq("abort_no_write", rd, 32'h0);
    xfer(2, 1'b0, 32'h10, 32'h0, rd, waits, resp);
    check_eq("rst_cleared_reg", rd, 32'h0);
    tick();

    // Deselected or non-transfer cycles are ignored
    xfer(1, 1'b1, 32'h1C, 32'h0000_0077, rd, waits, resp);
    check_eq("idx7_wr_waits", 32'(waits), 32'd0);
    repeat (4) tick();
    for (int c = 0; c < 3; c++) begin
      hsel   = (c != 0);
      htrans = (c == 0) ? TrNonseq : ((c == 1) ? TrBusy : TrIdle);
      hwrite = 1'b1;
      haddr  = 32'h1C;
      hwdata = 32'h0000_00AA;
      tick();
      check_eq("ignore_ready_ws0", 32'(rdy[1]), 32'd1);
      check_eq("ignore_ready_ws3", 32'(rdy[2]), 32'd1);
    end
    idle_bus();
    tick();
    xfer(1, 1'b0, 32'h1C, 32'h0, rd, waits, resp);
    check_eq("ignore_reg_kept", rd, 32'h0000_0077);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
